// File: rtl/openram_testchip_control.sv
// Control block of the OpenRAM test chip: holds one 112-bit SRAM command packet,
// loaded from the LA or GPIO scan, drives the shared SRAM buses and captures read data.
module openram_testchip_control (
    input  logic         la_clk,
    input  logic         reset,
    input  logic         in_select,
    input  logic         la_in_load,
    input  logic         la_sram_load,
    input  logic [111:0] la_data_in,
    input  logic         gpio_in,
    input  logic         gpio_scan,
    input  logic         gpio_sram_load,
    input  logic [31:0]  sram0_data0,
    input  logic [31:0]  sram0_data1,
    input  logic [31:0]  sram1_data0,
    input  logic [31:0]  sram1_data1,
    input  logic [31:0]  sram2_data0,
    input  logic [31:0]  sram2_data1,
    input  logic [31:0]  sram3_data0,
    input  logic [31:0]  sram3_data1,
    input  logic [31:0]  sram4_data0,
    input  logic [31:0]  sram4_data1,
    input  logic [31:0]  sram5_data0,
    input  logic [31:0]  sram5_data1,
    input  logic [31:0]  sram6_data0,
    input  logic [31:0]  sram6_data1,
    input  logic [31:0]  sram7_data0,
    input  logic [31:0]  sram7_data1,
    input  logic [31:0]  sram8_data0,
    input  logic [31:0]  sram8_data1,
    input  logic [31:0]  sram9_data0,
    input  logic [31:0]  sram9_data1,
    input  logic [31:0]  sram10_data0,
    input  logic [31:0]  sram10_data1,
    input  logic [31:0]  sram11_data0,
    input  logic [31:0]  sram11_data1,
    input  logic [31:0]  sram12_data0,
    input  logic [31:0]  sram12_data1,
    input  logic [31:0]  sram13_data0,
    input  logic [31:0]  sram13_data1,
    input  logic [31:0]  sram14_data0,
    input  logic [31:0]  sram14_data1,
    input  logic [31:0]  sram15_data0,
    input  logic [31:0]  sram15_data1,
    output logic [15:0]  left_addr0,
    output logic [15:0]  left_addr1,
    output logic [31:0]  left_din0,
    output logic [31:0]  left_din1,
    output logic         left_web0,
    output logic         left_web1,
    output logic [3:0]   left_wmask0,
    output logic [3:0]   left_wmask1,
    output logic [15:0]  left_csb0,
    output logic [15:0]  left_csb1,
    output logic [15:0]  right_addr0,
    output logic [31:0]  right_din0,
    output logic         right_web0,
    output logic [3:0]   right_wmask0,
    output logic [15:0]  right_csb0,
    output logic [111:0] la_data_out,
    output logic         gpio_out
);

    // Reset packet: both ports deselected and in read mode.
    localparam logic [111:0] RST_PKT = (112'd1 << 59) | (112'd1 << 58) | (112'd1 << 5) | (112'd1 << 4);

    logic [111:0] packet_q, packet_d;
    logic [3:0]   sel;
    logic [15:0]  addr0, addr1;
    logic [31:0]  din0, din1;
    logic         csb0, web0, csb1, web1;
    logic [3:0]   wmask0, wmask1;
    logic         load, sram_load;
    logic [31:0]  rd0_arr [16];
    logic [31:0]  rd1_arr [16];
    logic [31:0]  rd0, rd1;

    assign sel    = packet_q[111:108];
    assign addr0  = packet_q[107:92];
    assign din0   = packet_q[91:60];
    assign csb0   = packet_q[59];
    assign web0   = packet_q[58];
    assign wmask0 = packet_q[57:54];
    assign addr1  = packet_q[53:38];
    assign din1   = packet_q[37:6];
    assign csb1   = packet_q[5];
    assign web1   = packet_q[4];
    assign wmask1 = packet_q[3:0];

    assign rd0_arr[0]  = sram0_data0;   assign rd1_arr[0]  = sram0_data1;
    assign rd0_arr[1]  = sram1_data0;   assign rd1_arr[1]  = sram1_data1;
    assign rd0_arr[2]  = sram2_data0;   assign rd1_arr[2]  = sram2_data1;
    assign rd0_arr[3]  = sram3_data0;   assign rd1_arr[3]  = sram3_data1;
    assign rd0_arr[4]  = sram4_data0;   assign rd1_arr[4]  = sram4_data1;
    assign rd0_arr[5]  = sram5_data0;   assign rd1_arr[5]  = sram5_data1;
    assign rd0_arr[6]  = sram6_data0;   assign rd1_arr[6]  = sram6_data1;
    assign rd0_arr[7]  = sram7_data0;   assign rd1_arr[7]  = sram7_data1;
    assign rd0_arr[8]  = sram8_data0;   assign rd1_arr[8]  = sram8_data1;
    assign rd0_arr[9]  = sram9_data0;   assign rd1_arr[9]  = sram9_data1;
    assign rd0_arr[10] = sram10_data0;  assign rd1_arr[10] = sram10_data1;
    assign rd0_arr[11] = sram11_data0;  assign rd1_arr[11] = sram11_data1;
    assign rd0_arr[12] = sram12_data0;  assign rd1_arr[12] = sram12_data1;
    assign rd0_arr[13] = sram13_data0;  assign rd1_arr[13] = sram13_data1;
    assign rd0_arr[14] = sram14_data0;  assign rd1_arr[14] = sram14_data1;
    assign rd0_arr[15] = sram15_data0;  assign rd1_arr[15] = sram15_data1;

    assign rd0 = rd0_arr[sel];
    assign rd1 = rd1_arr[sel];

    // Only the selected source's controls are honoured.
    assign load      = in_select ? gpio_scan      : la_in_load;
    assign sram_load = in_select ? gpio_sram_load : la_sram_load;

    always_comb begin
        packet_d = packet_q;
        if (load) begin
            packet_d = in_select ? {packet_q[110:0], gpio_in} : la_data_in;
        end else if (sram_load) begin
            if (!csb0 && web0) packet_d[91:60] = rd0;
            if (!csb1 && web1) packet_d[37:6]  = rd1;
        end
    end

    always_ff @(posedge la_clk) begin
        if (reset) packet_q <= RST_PKT;
        else       packet_q <= packet_d;
    end

    assign left_addr0   = addr0;
    assign left_din0    = din0;
    assign left_web0    = web0;
    assign left_wmask0  = wmask0;
    assign left_addr1   = addr1;
    assign left_din1    = din1;
    assign left_web1    = web1;
    assign left_wmask1  = wmask1;
    assign right_addr0  = addr0;
    assign right_din0   = din0;
    assign right_web0   = web0;
    assign right_wmask0 = wmask0;

    // Slots 0-7 hang off the dual-port left bus, 8-15 off the single-port right bus.
    always_comb begin
        left_csb0  = '1;
        left_csb1  = '1;
        right_csb0 = '1;
        if (!sel[3]) begin
            left_csb0[sel] = csb0;
            left_csb1[sel] = csb1;
        end else begin
            right_csb0[sel] = csb0;
        end
    end

    assign la_data_out = {4'b0, packet_q[107:0]};
    assign gpio_out    = packet_q[111];

endmodule

// File: tb/tb_openram_testchip_control.sv
// Directed self-checking bench for openram_testchip_control.
module tb_openram_testchip_control;

    logic         la_clk = 1'b0;
    logic         reset, in_select, la_in_load, la_sram_load;
    logic [111:0] la_data_in;
    logic         gpio_in, gpio_scan, gpio_sram_load;
    logic [31:0]  sd0 [16];
    logic [31:0]  sd1 [16];
    logic [15:0]  left_addr0, left_addr1, left_csb0, left_csb1;
    logic [31:0]  left_din0, left_din1;
    logic         left_web0, left_web1;
    logic [3:0]   left_wmask0, left_wmask1;
    logic [15:0]  right_addr0, right_csb0;
    logic [31:0]  right_din0;
    logic         right_web0;
    logic [3:0]   right_wmask0;
    logic [111:0] la_data_out;
    logic         gpio_out;

    int total = 0;
    int bad   = 0;

    always #5 la_clk = ~la_clk;

    openram_testchip_control dut (
        .la_clk(la_clk), .reset(reset), .in_select(in_select),
        .la_in_load(la_in_load), .la_sram_load(la_sram_load), .la_data_in(la_data_in),
        .gpio_in(gpio_in), .gpio_scan(gpio_scan), .gpio_sram_load(gpio_sram_load),
        .sram0_data0(sd0[0]),   .sram0_data1(sd1[0]),
        .sram1_data0(sd0[1]),   .sram1_data1(sd1[1]),
        .sram2_data0(sd0[2]),   .sram2_data1(sd1[2]),
        .sram3_data0(sd0[3]),   .sram3_data1(sd1[3]),
        .sram4_data0(sd0[4]),   .sram4_data1(sd1[4]),
        .sram5_data0(sd0[5]),   .sram5_data1(sd1[5]),
        .sram6_data0(sd0[6]),   .sram6_data1(sd1[6]),
        .sram7_data0(sd0[7]),   .sram7_data1(sd1[7]),
        .sram8_data0(sd0[8]),   .sram8_data1(sd1[8]),
        .sram9_data0(sd0[9]),   .sram9_data1(sd1[9]),
        .sram10_data0(sd0[10]), .sram10_data1(sd1[10]),
        .sram11_data0(sd0[11]), .sram11_data1(sd1[11]),
        .sram12_data0(sd0[12]), .sram12_data1(sd1[12]),
        .sram13_data0(sd0[13]), .sram13_data1(sd1[13]),
        .sram14_data0(sd0[14]), .sram14_data1(sd1[14]),
        .sram15_data0(sd0[15]), .sram15_data1(sd1[15]),
        .left_addr0(left_addr0), .left_addr1(left_addr1),
        .left_din0(left_din0), .left_din1(left_din1),
        .left_web0(left_web0), .left_web1(left_web1),
        .left_wmask0(left_wmask0), .left_wmask1(left_wmask1),
        .left_csb0(left_csb0), .left_csb1(left_csb1),
        .right_addr0(right_addr0), .right_din0(right_din0), .right_web0(right_web0),
        .right_wmask0(right_wmask0), .right_csb0(right_csb0),
        .la_data_out(la_data_out), .gpio_out(gpio_out)
    );

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] mk(input logic [3:0] s, input logic [15:0] a0, input logic [31:0] d0,
                                        input logic c0, input logic w0, input logic [3:0] m0,
                                        input logic [15:0] a1, input logic [31:0] d1,
                                        input logic c1, input logic w1, input logic [3:0] m1);
        return {s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    function automatic logic [111:0] ro(input logic [111:0] p);
        return {4'b0, p[107:0]};
    endfunction

    task automatic tick();
        @(posedge la_clk);
        #1;
    endtask

    task automatic la_load(input logic [111:0] p);
        la_data_in = p; la_in_load = 1'b1;
        tick();
        la_in_load = 1'b0;
    endtask

    localparam logic [111:0] RST_RO = (112'd1 << 59) | (112'd1 << 58) | (112'd1 << 5) | (112'd1 << 4);
    localparam logic [111:0] PAT    = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 16'hC35A};

    initial begin
        logic [111:0] p, got;
        for (int i = 0; i < 16; i++) begin
            sd0[i] = 32'hA0000000 + i;
            sd1[i] = 32'hB0000000 + i;
        end
        reset = 1'b1; in_select = 1'b0; la_in_load = 1'b0; la_sram_load = 1'b0;
        la_data_in = '0; gpio_in = 1'b0; gpio_scan = 1'b0; gpio_sram_load = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_lcsb0", 112'(left_csb0), 112'(16'hFFFF));
        chk("rst_lcsb1", 112'(left_csb1), 112'(16'hFFFF));
        chk("rst_rcsb0", 112'(right_csb0), 112'(16'hFFFF));
        chk("rst_la_out", la_data_out, RST_RO);

        // Read capture from slots 0-4 and two right-bus slots
        for (int k = 0; k < 7; k++) begin
            logic [3:0] s;
            s = (k < 5) ? 4'(k) : (k == 5 ? 4'd9 : 4'd15);
            la_load(mk(s, 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd2, 32'd0, 1'b0, 1'b1, 4'd0));
            la_sram_load = 1'b1; tick(); la_sram_load = 1'b0;
            chk($sformatf("cap_sel%0d", s), la_data_out,
                mk(4'd0, 16'd1, 32'hA0000000 + 32'(s), 1'b0, 1'b1, 4'd0,
                   16'd2, 32'hB0000000 + 32'(s), 1'b0, 1'b1, 4'd0));
        end

        // Held capture is harmless
        la_sram_load = 1'b1; tick(); tick(); la_sram_load = 1'b0;
        chk("cap_hold", la_data_out,
            mk(4'd0, 16'd1, 32'hA000000F, 1'b0, 1'b1, 4'd0, 16'd2, 32'hB000000F, 1'b0, 1'b1, 4'd0));

        la_load(mk(4'd9, 16'h1234, 32'h0, 1'b0, 1'b1, 4'd0, 16'h0, 32'h0, 1'b0, 1'b1, 4'd0));
        chk("sel9_rcsb0", 112'(right_csb0), 112'(16'hFDFF));
        chk("sel9_lcsb0", 112'(left_csb0), 112'(16'hFFFF));
        chk("sel9_lcsb1", 112'(left_csb1), 112'(16'hFFFF));
        chk("sel9_raddr", 112'(right_addr0), 112'(16'h1234));

        la_load(mk(4'd3, 16'h0, 32'h0, 1'b1, 1'b1, 4'd0, 16'h0, 32'h0, 1'b0, 1'b1, 4'd0));
        chk("sel3_lcsb1", 112'(left_csb1), 112'(16'hFFF7));
        chk("sel3_lcsb0", 112'(left_csb0), 112'(16'hFFFF));
        chk("sel3_rcsb0", 112'(right_csb0), 112'(16'hFFFF));

        // Write packet: port 0 must not capture, port 1 reads
        la_load(mk(4'd2, 16'h0010, 32'h5555AAAA, 1'b0, 1'b0, 4'hF, 16'h0020, 32'h00001234, 1'b0, 1'b1, 4'h3));
        chk("wr_lcsb0", 112'(left_csb0), 112'(16'hFFFB));
        chk("wr_bus0", 112'({left_addr0, left_din0, left_web0, left_wmask0}), 112'({16'h0010, 32'h5555AAAA, 1'b0, 4'hF}));
        chk("wr_bus1", 112'({left_addr1, left_din1, left_web1, left_wmask1}), 112'({16'h0020, 32'h00001234, 1'b1, 4'h3}));
        chk("wr_rbus", 112'({right_din0, right_web0, right_wmask0}), 112'({32'h5555AAAA, 1'b0, 4'hF}));
        la_sram_load = 1'b1; tick(); la_sram_load = 1'b0;
        chk("wr_nocap", la_data_out,
            mk(4'd0, 16'h0010, 32'h5555AAAA, 1'b0, 1'b0, 4'hF, 16'h0020, 32'hB0000002, 1'b0, 1'b1, 4'h3));

        // GPIO scan-in, then scan-out MSB first
        in_select = 1'b1; gpio_scan = 1'b1;
        for (int i = 111; i >= 0; i--) begin
            gpio_in = PAT[i]; tick();
        end
        gpio_scan = 1'b0;
        chk("scan_in", la_data_out, ro(PAT));
        got = '0;
        gpio_in = 1'b0; gpio_scan = 1'b1;
        for (int i = 111; i >= 0; i--) begin
            got[i] = gpio_out; tick();
        end
        gpio_scan = 1'b0;
        chk("scan_out", got, PAT);
        chk("scan_zero", la_data_out, 112'd0);

        // Inactive-source controls are ignored
        p = mk(4'd5, 16'h00AA, 32'h0, 1'b0, 1'b1, 4'd0, 16'h00BB, 32'h0, 1'b0, 1'b1, 4'd0);
        in_select = 1'b0; la_load(p);
        in_select = 1'b1; la_data_in = PAT; la_in_load = 1'b1; la_sram_load = 1'b1; tick();
        la_in_load = 1'b0; la_sram_load = 1'b0;
        chk("gpio_ign_la", la_data_out, ro(p));
        gpio_sram_load = 1'b1; tick(); gpio_sram_load = 1'b0;
        chk("gpio_cap", la_data_out,
            mk(4'd0, 16'h00AA, 32'hA0000005, 1'b0, 1'b1, 4'd0, 16'h00BB, 32'hB0000005, 1'b0, 1'b1, 4'd0));
        in_select = 1'b0; la_load(p);
        gpio_scan = 1'b1; gpio_in = 1'b1; gpio_sram_load = 1'b1; tick();
        gpio_scan = 1'b0; gpio_in = 1'b0; gpio_sram_load = 1'b0;
        chk("la_ign_gpio", la_data_out, ro(p));

        // Reset beats load on the same edge
        la_data_in = PAT; la_in_load = 1'b1; reset = 1'b1; tick();
        la_in_load = 1'b0; reset = 1'b0;
        chk("rst_vs_load", la_data_out, RST_RO);
        chk("rst_gpio_out", 112'(gpio_out), 112'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/openram_testchip_control.md
# openram_testchip_control

Control block of the OpenRAM test chip. It holds one 112-bit SRAM command packet, loaded in parallel from the logic analyzer (LA) or serially via GPIO scan. The packet drives the shared address, data, mask and write-enable buses and the per-macro chip selects of 16 SRAM slots: slots 0-7 are dual-port (left bus) and slots 8-15 are single-port (right bus). Read data from the selected macro is captured back into the packet for LA or GPIO readout.

## Interface
- No parameters. Fixed widths: ADDR=16, DATA=32, WMASK=4, CHIPS=16, TOTAL=112.
- Packet layout, MSB to LSB: sel[111:108], addr0[107:92], din0[91:60], csb0[59], web0[58], wmask0[57:54], addr1[53:38], din1[37:6], csb1[5], web1[4], wmask1[3:0].
- la_clk  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_select  in  1  source select: 0 = LA controls, 1 = GPIO controls.
- la_in_load  in  1  parallel-load la_data_in into the packet.
- la_sram_load  in  1  capture SRAM read data (LA mode).
- la_data_in  in  112  packet from LA.
- gpio_in  in  1  serial scan data.
- gpio_scan  in  1  shift the packet by one bit.
- gpio_sram_load  in  1  capture SRAM read data (GPIO mode).
- sramN_data0, sramN_data1 (N=0..15)  in  32 each  read data, port 0 and port 1, of slot N.
- left_addr0/left_addr1  out  16; left_din0/left_din1  out  32; left_web0/left_web1  out  1; left_wmask0/left_wmask1  out  4; left_csb0/left_csb1  out  16, active-low per-slot selects.
- right_addr0  out  16; right_din0  out  32; right_web0  out  1; right_wmask0  out  4; right_csb0  out  16.
- la_data_out  out  112  packet readout.
- gpio_out  out  1  serial scan out.

## Operation
- Active controls: when in_select=0, load = la_in_load and sram_load = la_sram_load. When in_select=1, load = gpio_scan and sram_load = gpio_sram_load. Controls of the inactive source are ignored.
- Priority on each la_clk edge: reset, then load/scan, then sram_load, else hold.
- Reset value: all bits 0 except csb0=csb1=web0=web1=1, so no macro is selected and no write occurs.
- LA load: packet <= la_data_in.
- GPIO scan: packet <= {packet[110:0], gpio_in}. gpio_out = packet[111], combinational from the register.
- SRAM capture when sram_load=1:
  - If csb0=0 and web0=1, din0 <= sram[sel]_data0.
  - If csb1=0 and web1=1, din1 <= sram[sel]_data1.
  - All other fields hold.
- Bus drive: combinational, driven continuously from the packet.
  - left_* port-0 signals = addr0, din0, web0, wmask0; left_* port-1 signals = addr1, din1, web1, wmask1.
  - right_* signals = addr0, din0, web0, wmask0.
- Chip selects, all bits default 1:
  - sel<8: left_csb0[sel]=csb0 and left_csb1[sel]=csb1.
  - sel>=8: right_csb0[sel]=csb0.
  - right_csb0 bits 0-7 and left_csb bits 8-15 are always 1.
- la_data_out = {4'b0, packet[107:0]}. The sel field always reads back as zero.
- Empty slots are read through their tied-off data inputs like any other slot; no special handling.

## Timing
- Load, scan and capture each take effect on the la_clk edge where they are sampled. la_data_out and the buses reflect the new packet after that edge.
- The SRAM macros are clocked externally. Read data must be stable before the capturing la_clk edge. Capturing repeatedly while sram_load is held is harmless.
- A full GPIO scan-in takes 112 edges. Old packet bits emerge MSB-first on gpio_out during the scan.
- Reset in mid-scan or mid-capture wins and restores the reset value on that same edge.
- Switching in_select takes effect on the next edge; no state is lost.

## Test plan
- Reset asserted for 1 cycle -> left_csb0/left_csb1/right_csb0 = 16'hFFFF; la_data_out has bits 59, 58, 5 and 4 set, all others 0.
- Slots 0-4: write addr 1 = 1, then addr 2 = 2 (port 0, wmask0=4'hF, csb1=1). Then load {sel, 16'd1, 32'd0, 0, 1, 4'd0, 16'd2, 32'd0, 0, 1, 4'd0} and pulse sram_load -> la_data_out = {4'd0, 16'd1, 32'd1, 0, 1, 4'd0, 16'd2, 32'd2, 0, 1, 4'd0}.
- sel=9 with csb0=0 -> right_csb0 = 16'hFDFF and left_csb0 = 16'hFFFF. sel=3 with csb1=0 -> left_csb1 = 16'hFFF7.
- in_select=1: scan in 112 bits of a known pattern via gpio_in -> la_data_out equals that pattern with the sel field zeroed. Scan 112 more edges -> gpio_out reproduces the pattern MSB-first.
- in_select=1 with la_in_load=1 -> packet unchanged. in_select=0 with gpio_scan=1 -> packet unchanged.
- Write packet (web0=0) with sram_load=1 -> din0 unchanged. Reset asserted together with la_in_load -> reset value wins.
